mainfsm_ctrl: RTL and testbench

//  Multicycle ARM main control FSM; sits directly upstream of the conditional-logic stage.

---
 rtl/mainfsm_ctrl.sv | 158 +++++++++++++++
 tb/tb_mainfsm_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mainfsm_ctrl.sv
// Multicycle ARM main control FSM: fetch/decode/execute/writeback sequencing and datapath selects.
// Define MAINFSM_PERF_EN to add the CycCnt/InstrCnt performance counters.
module mainfsm_ctrl
`ifdef MAINFSM_PERF_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic       Illegal,
   output logic [3:0] dbg_state
`ifdef MAINFSM_PERF_EN
   ,
   output logic [CNT_W-1:0] CycCnt,
   output logic [CNT_W-1:0] InstrCnt
`endif
);

   // Handshake: MemReady=1 in FETCH, MEMRD or MEMWR means the memory access
   // completes on the coming clock edge; those states hold while it is 0.

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECR   = 4'd6,
      EXECI   = 4'd7,
      ALUWB   = 4'd8,
      BRANCH  = 4'd9,
      UNKNOWN = 4'd10
   } state_t;

   state_t state, state_nxt;

   logic unused_funct;
   assign unused_funct = ^Funct[4:1];

   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = FETCH;
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ALUOp     = 1'b0;
      Illegal   = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            // Gating with reset keeps the fetch strobes quiet while reset is held.
            IRWrite   = MemReady & reset;
            NextPC    = MemReady & reset;
            state_nxt = MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
               2'b01:   state_nxt = MEMADR;
               2'b10:   state_nxt = BRANCH;
               default: state_nxt = UNKNOWN;
            endcase
         end
         MEMADR: begin
            ALUSrcB   = 2'b01;
            state_nxt = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc    = 1'b1;
            state_nxt = MemReady ? MEMWB : MEMRD;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
            state_nxt = FETCH;
         end
         MEMWR: begin
            AdrSrc    = 1'b1;
            MemW      = 1'b1;
            state_nxt = MemReady ? FETCH : MEMWR;
         end
         EXECR: begin
            ALUOp     = 1'b1;
            state_nxt = ALUWB;
         end
         EXECI: begin
            ALUSrcB   = 2'b01;
            ALUOp     = 1'b1;
            state_nxt = ALUWB;
         end
         ALUWB: begin
            RegW      = 1'b1;
            state_nxt = FETCH;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            Branch    = 1'b1;
            state_nxt = FETCH;
         end
         UNKNOWN: begin
            Illegal   = 1'b1;
            state_nxt = UNKNOWN;
         end
         default: begin
            // Unreachable codes look illegal for one cycle, then recover to FETCH.
            Illegal   = 1'b1;
            state_nxt = FETCH;
         end
      endcase
   end

`ifdef MAINFSM_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         CycCnt   <= '0;
         InstrCnt <= '0;
      end else if (!Illegal) begin
         CycCnt <= CycCnt + 1'b1;
         if (state == FETCH && MemReady) InstrCnt <= InstrCnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mainfsm_ctrl.sv
// Scoreboard bench for mainfsm_ctrl: an instruction-level model pushes per-cycle
// expected outputs, a negedge monitor pops and compares.
module tb_mainfsm_ctrl;

   localparam int CW = 4;
   localparam int VW = 13;

   typedef enum int {
      P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB,
      P_MEMWR, P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_UNK
   } phase_e;

   logic       clk;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemReady;
   logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp, Illegal;
   logic [1:0] ALUSrcB, ResultSrc;
   logic [3:0] dbg_state;

   logic [VW-1:0] exp_q[$];
   logic [VW-1:0] dut_vec;
   int checks = 0;
   int errors = 0;

`ifdef MAINFSM_PERF_EN
   logic [CW-1:0] CycCnt, InstrCnt;
   logic [2*CW-1:0] cnt_q[$];
   int model_cyc = 0;
   int model_instr = 0;

   mainfsm_ctrl #(.CNT_W(CW)) dut (
`else
   mainfsm_ctrl dut (
`endif
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
      .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ALUOp(ALUOp), .Illegal(Illegal), .dbg_state(dbg_state)
`ifdef MAINFSM_PERF_EN
      , .CycCnt(CycCnt), .InstrCnt(InstrCnt)
`endif
   );

   assign dut_vec = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
                     ALUSrcB, ResultSrc, ALUOp, Illegal};

   // clock/reset: negedge first so each driven cycle is checked before its edge
   initial clk = 1'b1;
   always #5 clk = ~clk;

   // Expected outputs for one cycle, straight from the per-state output table.
   function automatic logic [VW-1:0] model_out(input phase_e ph, input logic mr);
      logic ir, npc, rw, mw, br, adr, sa, op, ill;
      logic [1:0] sb, rs;
      {ir, npc, rw, mw, br, adr, sa, op, ill} = '0;
      sb = 2'b00;
      rs = 2'b00;
      case (ph)
         P_RST:    begin sa = 1; sb = 2'b10; rs = 2'b10; end
         P_FETCH:  begin sa = 1; sb = 2'b10; rs = 2'b10; ir = mr; npc = mr; end
         P_DECODE: begin sa = 1; sb = 2'b10; rs = 2'b10; end
         P_MEMADR: begin sb = 2'b01; end
         P_MEMRD:  begin adr = 1; end
         P_MEMWB:  begin rs = 2'b01; rw = 1; end
         P_MEMWR:  begin adr = 1; mw = 1; end
         P_EXECR:  begin op = 1; end
         P_EXECI:  begin sb = 2'b01; op = 1; end
         P_ALUWB:  begin rw = 1; end
         P_BRANCH: begin sb = 2'b01; rs = 2'b10; br = 1; end
         default:  begin ill = 1; end
      endcase
      return {ir, npc, rw, mw, br, adr, sa, sb, rs, op, ill};
   endfunction

   // driver: one clock cycle in the given phase
   task automatic step(input phase_e ph, input logic mr);
      reset    = (ph != P_RST);
      MemReady = mr;
      exp_q.push_back(model_out(ph, mr));
`ifdef MAINFSM_PERF_EN
      if (ph == P_RST) begin
         model_cyc   = 0;
         model_instr = 0;
      end
      cnt_q.push_back({model_instr[CW-1:0], model_cyc[CW-1:0]});
      if (ph != P_RST && ph != P_UNK) begin
         model_cyc = (model_cyc + 1) % (1 << CW);
         if (ph == P_FETCH && mr) model_instr = (model_instr + 1) % (1 << CW);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One instruction from FETCH to its last state; abort=1 resets after DECODE.
   task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                            input int fetch_stall, input int mem_stall, input bit abort);
      Op    = op;
      Funct = funct;
      for (int i = 0; i < fetch_stall; i++) step(P_FETCH, 1'b0);
      step(P_FETCH, 1'b1);
      step(P_DECODE, rnd_bit());
      if (abort) begin
         step(P_RST, rnd_bit());
         return;
      end
      case (op)
         2'b00: begin
            step(funct[5] ? P_EXECI : P_EXECR, rnd_bit());
            step(P_ALUWB, rnd_bit());
         end
         2'b01: begin
            step(P_MEMADR, rnd_bit());
            for (int i = 0; i < mem_stall; i++) step(funct[0] ? P_MEMRD : P_MEMWR, 1'b0);
            step(funct[0] ? P_MEMRD : P_MEMWR, 1'b1);
            if (funct[0]) step(P_MEMWB, rnd_bit());
         end
         2'b10: step(P_BRANCH, rnd_bit());
         default: begin
            for (int i = 0; i < 3; i++) step(P_UNK, rnd_bit());
            step(P_RST, rnd_bit());
         end
      endcase
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      logic [VW-1:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (dut_vec !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got=%b expected=%b (IRW NPC RW MW BR ADR SA SB RS OP ILL)",
                     $time, dut_vec, e);
         end
      end
`ifdef MAINFSM_PERF_EN
      if (cnt_q.size() != 0) begin
         logic [2*CW-1:0] c;
         c = cnt_q.pop_front();
         checks++;
         if ({InstrCnt, CycCnt} !== c) begin
            errors++;
            $display("FAIL counters t=%0t got instr=%0d cyc=%0d expected instr=%0d cyc=%0d",
                     $time, InstrCnt, CycCnt, c[2*CW-1:CW], c[CW-1:0]);
         end
      end
`endif
   end

   initial begin
      reset    = 1'b0;
      MemReady = 1'b1;
      Op       = 2'b00;
      Funct    = 6'd0;
      // reset held with MemReady=1: FETCH selects, fetch strobes quiet
      step(P_RST, 1'b1);
      step(P_RST, 1'b1);
      // directed: ALU reg, ALU imm, load with 3 stalls, store after 2 fetch stalls, branch
      run_instr(2'b00, 6'b000000, 0, 0, 0);
      run_instr(2'b00, 6'b100000, 0, 0, 0);
      run_instr(2'b01, 6'b000001, 0, 3, 0);
      run_instr(2'b01, 6'b000000, 2, 0, 0);
      run_instr(2'b10, 6'b000000, 0, 0, 0);
      // illegal op: sticky until reset
      run_instr(2'b11, 6'b000000, 0, 0, 0);
      // 20 single-cycle ALU instructions: counters wrap to instr=4, cyc=0
      step(P_RST, 1'b1);
      for (int i = 0; i < 20; i++) run_instr(2'b00, 6'($urandom), 0, 0, 0);
      // randomized mix with stalls, illegal ops and mid-instruction resets
      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         op = (($urandom_range(0, 9)) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         run_instr(op, 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 11) == 0));
      end
      step(P_FETCH, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
